pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised next-PC unit for the RISC fetch stage; successor to the single-width next-address block.
//  Registers the program counter and each cycle selects sequential, conditional-branch, absolute-jump,
//  jump-register, call or return target. Adds a RAS_DEPTH-entry return-address stack, a stall
//  handshake, an always-taken branch type and sign-extended branch offsets.
// PARAMETERS
//  ADDR_W     32  PC / address width in bits
//  OFF_W      16  branch offset width; sign-extended to ADDR_W
//  JMP_W      26  absolute jump label width; ADDR_W >= JMP_W+2 required
//  RAS_DEPTH   4  return-address stack entries, >= 2
//  RESET_PC    0  PC value loaded on reset
// PORTS
//  clk        in   1          clock, rising edge
//  reset_n    in   1          synchronous reset, active-low
//  stall      in   1          1 = hold pc and RAS, ignore selects
//  zero_flag  in   1          ALU zero
//  carry_flag in   1          ALU carry
//  msb        in   1          ALU result sign bit
//  brtype     in   3          branch condition: 0 msb, 1 Z, 2 !Z, 3 C, 4 !C, 5 always, 6/7 never
//  pc_sel     in   3          0 seq/branch, 1 jump, 2 jump-reg, 3 call, 4 return, 5-7 treated as 0
//  branch_off in   OFF_W      signed branch offset, in words
//  jmp_label  in   JMP_W      absolute jump label
//  jmp_ra     in   ADDR_W     register target for pc_sel=2; fallback target for return on empty RAS
//  pc         out  ADDR_W     registered current PC
//  next_pc    out  ADDR_W     combinational PC to be loaded at the next edge
//  br_taken   out  1          combinational: pc_sel=0 and condition true
//  ras_count  out  clog2(RAS_DEPTH+1)  valid RAS entries, registered
//  ras_ovf    out  1          sticky: a push occurred while the RAS was full
//  ras_unf    out  1          sticky: a pop occurred while the RAS was empty
// BEHAVIOUR
//  Reset (reset_n=0 at posedge clk) applies regardless of stall:
//   - pc=RESET_PC, ras_count=0, ras_ovf=0, ras_unf=0; RAS contents are don't-care.
//   - Overrides any in-flight call/return in the same cycle.
//  Sequential address: seq = pc + 1 (word addressed). All arithmetic is modulo 2^ADDR_W; wrap is silent.
//  Branch and jump targets:
//   - brt = seq + sext(branch_off) when br_taken, else seq.
//   - jmp = {pc[ADDR_W-1:JMP_W+2], jmp_label, 2'b00}; upper field is empty when ADDR_W = JMP_W+2.
//  next_pc by pc_sel:
//   - 0: brt.
//   - 1: jmp.
//   - 2: jmp_ra.
//   - 3: jmp, and push seq.
//   - 4: top of RAS and pop; if RAS is empty, jmp_ra, count stays 0, ras_unf is set.
//  The condition mux is fully decoded (no latch); brtype 6/7 gives not-taken.
//  Timing: pc <= next_pc on each posedge with stall=0, so a target is visible on pc one cycle after select.
//  Stall=1: pc, RAS and flags hold; next_pc still shows the would-be target; no push or pop occurs.
//  RAS is a circular LIFO:
//   - Push when full overwrites the oldest entry; count stays RAS_DEPTH; ras_ovf is set.
//   - Only one push or pop per cycle; call and return are mutually exclusive by encoding.
//  ras_ovf and ras_unf clear only on reset.
// TESTING
//  1 Reset: reset_n=0 for 2 clocks -> pc=0, ras_count=0, both flags 0; then pc counts 0,1,2,3 with pc_sel=0, brtype=6.
//  2 Branch: pc=10, pc_sel=0, brtype=1, zero_flag=1, branch_off=16'hFFFC -> pc=7; same with zero_flag=0 -> pc=11.
//  3 Jump: pc=32'hA000_0004, pc_sel=1, jmp_label=26'h3 -> pc=32'hA000_000C; pc_sel=2, jmp_ra=32'h1234 -> pc=32'h1234.
//  4 Call/return: call at pc=5 -> RAS holds 6, count=1; later return -> pc=6, count=0.
//    Return on empty RAS with jmp_ra=99 -> pc=99, ras_unf=1.
//  5 Overflow: 5 calls at pc=1..5 with RAS_DEPTH=4 -> count=4, ras_ovf=1; 4 returns -> pc 6,5,4,3.
//  6 Stall and wrap: stall=1 with pc_sel=3 for 3 cycles -> pc and count unchanged;
//    pc=32'hFFFF_FFFF with seq select -> pc=0; reset mid-stall -> pc=RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC unit for the fetch stage: registered PC, branch/jump/call/return target selection,
// and a circular return-address stack with sticky overflow/underflow flags.
module pc_sequencer #(
    parameter int ADDR_W    = 32,
    parameter int OFF_W     = 16,
    parameter int JMP_W     = 26,
    parameter int RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int CNT_W    = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              zero_flag,
    input  logic              carry_flag,
    input  logic              msb,
    input  logic [2:0]        brtype,
    input  logic [2:0]        pc_sel,
    input  logic [OFF_W-1:0]  branch_off,
    input  logic [JMP_W-1:0]  jmp_label,
    input  logic [ADDR_W-1:0] jmp_ra,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_pc,
    output logic              br_taken,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_ovf,
    output logic              ras_unf
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] ONE      = 1;
    // Bits below this mask come from the jump label; bits above are kept from the current PC.
    localparam logic [ADDR_W-1:0] LOW_MASK = (ONE << (JMP_W + 2)) - ONE;

    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;

    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] brt;
    logic [ADDR_W-1:0] jmp;
    logic [ADDR_W-1:0] off_ext;
    logic              cond;
    logic              do_push;
    logic              do_pop;
    logic              do_unf;

    assign seq     = pc + ONE;
    assign off_ext = {{(ADDR_W - OFF_W){branch_off[OFF_W-1]}}, branch_off};
    assign jmp     = (pc & ~LOW_MASK) | ({{(ADDR_W - JMP_W){1'b0}}, jmp_label} << 2);
    assign ptr_inc = (ras_ptr == PTR_LAST) ? '0 : ras_ptr + 1'b1;
    assign ptr_dec = (ras_ptr == '0) ? PTR_LAST : ras_ptr - 1'b1;

    always_comb begin
        cond = 1'b0;
        case (brtype)
            3'd0:    cond = msb;
            3'd1:    cond = zero_flag;
            3'd2:    cond = ~zero_flag;
            3'd3:    cond = carry_flag;
            3'd4:    cond = ~carry_flag;
            3'd5:    cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign br_taken = ((pc_sel == 3'd0) || (pc_sel > 3'd4)) && cond;
    assign brt      = br_taken ? seq + off_ext : seq;

    always_comb begin
        next_pc = brt;
        do_push = 1'b0;
        do_pop  = 1'b0;
        do_unf  = 1'b0;
        case (pc_sel)
            3'd1: next_pc = jmp;
            3'd2: next_pc = jmp_ra;
            3'd3: begin
                next_pc = jmp;
                do_push = 1'b1;
            end
            3'd4: begin
                if (ras_count != '0) begin
                    next_pc = ras[ptr_dec];
                    do_pop  = 1'b1;
                end else begin
                    next_pc = jmp_ra;
                    do_unf  = 1'b1;
                end
            end
            default: next_pc = brt;
        endcase
    end

    // A push when full lands on the oldest slot because the pointer has wrapped onto it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc        <= RESET_PC;
            ras_ptr   <= '0;
            ras_count <= '0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
        end else if (!stall) begin
            pc <= next_pc;
            if (do_push) begin
                ras_ptr <= ptr_inc;
                if (ras_count == CNT_FULL) begin
                    ras_ovf <= 1'b1;
                end else begin
                    ras_count <= ras_count + 1'b1;
                end
            end else if (do_pop) begin
                ras_ptr   <= ptr_dec;
                ras_count <= ras_count - 1'b1;
            end else if (do_unf) begin
                ras_unf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && !stall && do_push) begin
            ras[ras_ptr] <= seq;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with default parameters.
module tb_pc_sequencer;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        zero_flag;
    logic        carry_flag;
    logic        msb;
    logic [2:0]  brtype;
    logic [2:0]  pc_sel;
    logic [15:0] branch_off;
    logic [25:0] jmp_label;
    logic [31:0] jmp_ra;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        br_taken;
    logic [2:0]  ras_count;
    logic        ras_ovf;
    logic        ras_unf;

    int n_compared;
    int n_mismatched;

    // {brtype, zero_flag, carry_flag, msb, expected taken}
    localparam logic [6:0] BR_VEC [11] = '{
        {3'd0, 1'b0, 1'b0, 1'b1, 1'b1},
        {3'd0, 1'b1, 1'b1, 1'b0, 1'b0},
        {3'd1, 1'b1, 1'b0, 1'b0, 1'b1},
        {3'd2, 1'b0, 1'b0, 1'b0, 1'b1},
        {3'd2, 1'b1, 1'b0, 1'b0, 1'b0},
        {3'd3, 1'b0, 1'b1, 1'b0, 1'b1},
        {3'd4, 1'b0, 1'b1, 1'b0, 1'b0},
        {3'd4, 1'b0, 1'b0, 1'b0, 1'b1},
        {3'd5, 1'b0, 1'b0, 1'b0, 1'b1},
        {3'd6, 1'b1, 1'b1, 1'b1, 1'b0},
        {3'd7, 1'b1, 1'b1, 1'b1, 1'b0}
    };

    pc_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .msb        (msb),
        .brtype     (brtype),
        .pc_sel     (pc_sel),
        .branch_off (branch_off),
        .jmp_label  (jmp_label),
        .jmp_ra     (jmp_ra),
        .pc         (pc),
        .next_pc    (next_pc),
        .br_taken   (br_taken),
        .ras_count  (ras_count),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        pc_sel  = 3'd0;
        brtype  = 3'd6;
        stall   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic load_pc(input logic [31:0] addr);
        stall  = 1'b0;
        pc_sel = 3'd2;
        jmp_ra = addr;
        tick();
        pc_sel = 3'd0;
        brtype = 3'd6;
    endtask

    task automatic test_reset();
        do_reset();
        n_compared++;
        if (pc !== 32'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'd0);
        end
        n_compared++;
        if (ras_count !== 3'd0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_ras: got cnt=%0d ovf=%b unf=%b expected 0 0 0", ras_count, ras_ovf, ras_unf);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_compared++;
            if (pc !== 32'(i)) begin
                n_mismatched++;
                $display("[TB] FAIL seq_count: got %h expected %h", pc, 32'(i));
            end
        end
    endtask

    task automatic test_branch();
        load_pc(32'd10);
        brtype     = 3'd1;
        zero_flag  = 1'b1;
        branch_off = 16'hFFFC;
        tick();
        n_compared++;
        if (pc !== 32'd7) begin
            n_mismatched++;
            $display("[TB] FAIL branch_back_taken: got %h expected %h", pc, 32'd7);
        end
        load_pc(32'd10);
        brtype    = 3'd1;
        zero_flag = 1'b0;
        tick();
        n_compared++;
        if (pc !== 32'd11) begin
            n_mismatched++;
            $display("[TB] FAIL branch_not_taken: got %h expected %h", pc, 32'd11);
        end
        // Hold pc at 20 with stall and sweep every condition through next_pc/br_taken.
        load_pc(32'd20);
        stall      = 1'b1;
        branch_off = 16'd4;
        for (int i = 0; i < 11; i++) begin
            logic [6:0] v;
            v          = BR_VEC[i];
            brtype     = v[6:4];
            zero_flag  = v[3];
            carry_flag = v[2];
            msb        = v[1];
            #1;
            n_compared++;
            if (br_taken !== v[0] || next_pc !== (v[0] ? 32'd25 : 32'd21)) begin
                n_mismatched++;
                $display("[TB] FAIL brtype_%0d: got taken=%b next=%h expected taken=%b next=%h",
                         v[6:4], br_taken, next_pc, v[0], v[0] ? 32'd25 : 32'd21);
            end
        end
        pc_sel = 3'd6;
        brtype = 3'd5;
        #1;
        n_compared++;
        if (br_taken !== 1'b1 || next_pc !== 32'd25) begin
            n_mismatched++;
            $display("[TB] FAIL pc_sel6_as_seq: got taken=%b next=%h expected 1 %h", br_taken, next_pc, 32'd25);
        end
        stall  = 1'b0;
        pc_sel = 3'd0;
        brtype = 3'd6;
    endtask

    task automatic test_jump();
        load_pc(32'hA000_0004);
        pc_sel    = 3'd1;
        jmp_label = 26'h3;
        tick();
        n_compared++;
        if (pc !== 32'hA000_000C) begin
            n_mismatched++;
            $display("[TB] FAIL jump_abs: got %h expected %h", pc, 32'hA000_000C);
        end
        pc_sel = 3'd2;
        jmp_ra = 32'h1234;
        tick();
        n_compared++;
        if (pc !== 32'h1234) begin
            n_mismatched++;
            $display("[TB] FAIL jump_reg: got %h expected %h", pc, 32'h1234);
        end
        pc_sel = 3'd0;
    endtask

    task automatic test_call_return();
        do_reset();
        load_pc(32'd5);
        pc_sel    = 3'd3;
        jmp_label = 26'h10;
        tick();
        n_compared++;
        if (pc !== 32'h40 || ras_count !== 3'd1) begin
            n_mismatched++;
            $display("[TB] FAIL call: got pc=%h cnt=%0d expected pc=%h cnt=1", pc, ras_count, 32'h40);
        end
        pc_sel = 3'd0;
        brtype = 3'd6;
        tick();
        pc_sel = 3'd4;
        jmp_ra = 32'd200;
        tick();
        n_compared++;
        if (pc !== 32'd6 || ras_count !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL return: got pc=%h cnt=%0d expected pc=%h cnt=0", pc, ras_count, 32'd6);
        end
        n_compared++;
        if (ras_unf !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL unf_before_empty_pop: got %b expected 0", ras_unf);
        end
        jmp_ra = 32'd99;
        tick();
        n_compared++;
        if (pc !== 32'd99 || ras_count !== 3'd0 || ras_unf !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL return_empty: got pc=%h cnt=%0d unf=%b expected pc=%h cnt=0 unf=1",
                     pc, ras_count, ras_unf, 32'd99);
        end
        pc_sel = 3'd0;
    endtask

    task automatic test_overflow();
        do_reset();
        jmp_label = 26'h0;
        for (int i = 1; i <= 5; i++) begin
            load_pc(32'(i));
            pc_sel = 3'd3;
            tick();
        end
        pc_sel = 3'd0;
        n_compared++;
        if (ras_count !== 3'd4 || ras_ovf !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL overflow: got cnt=%0d ovf=%b expected cnt=4 ovf=1", ras_count, ras_ovf);
        end
        pc_sel = 3'd4;
        jmp_ra = 32'd500;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_compared++;
            if (pc !== 32'(6 - i)) begin
                n_mismatched++;
                $display("[TB] FAIL ovf_return_%0d: got %h expected %h", i, pc, 32'(6 - i));
            end
        end
        n_compared++;
        if (ras_count !== 3'd0 || ras_ovf !== 1'b1 || ras_unf !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL ovf_drained: got cnt=%0d ovf=%b unf=%b expected 0 1 0", ras_count, ras_ovf, ras_unf);
        end
        pc_sel = 3'd0;
    endtask

    task automatic test_stall_wrap();
        do_reset();
        load_pc(32'd50);
        stall     = 1'b1;
        pc_sel    = 3'd3;
        jmp_label = 26'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_compared++;
            if (pc !== 32'd50 || ras_count !== 3'd0 || next_pc !== 32'd0) begin
                n_mismatched++;
                $display("[TB] FAIL stall_hold_%0d: got pc=%h cnt=%0d next=%h expected pc=%h cnt=0 next=0",
                         i, pc, ras_count, next_pc, 32'd50);
            end
        end
        load_pc(32'hFFFF_FFFF);
        tick();
        n_compared++;
        if (pc !== 32'd0) begin
            n_mismatched++;
            $display("[TB] FAIL wrap: got %h expected %h", pc, 32'd0);
        end
        load_pc(32'd77);
        pc_sel = 3'd3;
        tick();
        pc_sel  = 3'd3;
        stall   = 1'b1;
        reset_n = 1'b0;
        tick();
        n_compared++;
        if (pc !== 32'd0 || ras_count !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_stall: got pc=%h cnt=%0d expected pc=0 cnt=0", pc, ras_count);
        end
        load_pc(32'd30);
        pc_sel  = 3'd3;
        reset_n = 1'b0;
        tick();
        n_compared++;
        if (pc !== 32'd0 || ras_count !== 3'd0 || ras_ovf !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_over_call: got pc=%h cnt=%0d ovf=%b expected 0 0 0", pc, ras_count, ras_ovf);
        end
        reset_n = 1'b1;
        stall   = 1'b0;
        pc_sel  = 3'd0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset_n      = 1'b0;
        stall        = 1'b0;
        zero_flag    = 1'b0;
        carry_flag   = 1'b0;
        msb          = 1'b0;
        brtype       = 3'd6;
        pc_sel       = 3'd0;
        branch_off   = '0;
        jmp_label    = '0;
        jmp_ra       = '0;
        #2;
        test_reset();
        test_branch();
        test_jump();
        test_call_return();
        test_overflow();
        test_stall_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
